// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: step-mode encoding and
// the two-state control FSM.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD = 3'b000,
    USR_SHR  = 3'b001,
    USR_SHL  = 3'b010,
    USR_LOAD = 3'b011,
    USR_ROR  = 3'b100,
    USR_ROL  = 3'b101,
    USR_ASR  = 3'b110,
    USR_RSVD = 3'b111
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_step_unit.sv
// Combinational one-step transform of the register contents for a given mode.
// Shared by the single-step (en) path and the multi-step (start) path.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  usr_mode_e        mode,
  input  logic             s_left_din,
  input  logic             s_right_din,
  input  logic [WIDTH-1:0] parallel_din,
  output logic [WIDTH-1:0] next_q
);

  // Select the next register value for one step of the requested mode
  always_comb begin
    next_q = q;
    case (mode)
      USR_HOLD: next_q = q;
      USR_SHR:  next_q = {s_right_din, q[WIDTH-1:1]};
      USR_SHL:  next_q = {q[WIDTH-2:0], s_left_din};
      USR_LOAD: next_q = parallel_din;
      USR_ROR:  next_q = {q[0], q[WIDTH-1:1]};
      USR_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      USR_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  next_q = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register with single-step enable and a
// multi-step "shift by amount" operation using a start/busy/done handshake.
module univ_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  input  logic             s_left_din,
  input  logic             s_right_din,
  input  logic [WIDTH-1:0] parallel_din,
  output logic [WIDTH-1:0] parallel_dout,
  output logic             s_left_dout,
  output logic             s_right_dout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  usr_state_e       state_r, state_s;
  usr_mode_e        op_mode_r, op_mode_s;
  usr_mode_e        step_mode_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] q_r, q_s, step_q_s;
  logic             done_r, done_s;

  // While running, the latched op_mode drives the step unit; otherwise live mode
  assign step_mode_s = (state_r == RUN) ? op_mode_r : usr_mode_e'(mode);

  usr_step_unit #(.WIDTH(WIDTH)) u_step (
    .q            (q_r),
    .mode         (step_mode_s),
    .s_left_din   (s_left_din),
    .s_right_din  (s_right_din),
    .parallel_din (parallel_din),
    .next_q       (step_q_s)
  );

  // Next-state, counter, register and done decode for the IDLE/RUN FSM
  always_comb begin
    state_s   = state_r;
    op_mode_s = op_mode_r;
    cnt_s     = cnt_r;
    q_s       = q_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          // Accept edge only latches the operation; no step is applied here
          op_mode_s = usr_mode_e'(mode);
          cnt_s     = shamt;
          if (shamt != CNT_ZERO) begin
            state_s = RUN;
          end else begin
            done_s = 1'b1;
          end
        end else if (en) begin
          q_s = step_q_s;
        end else begin
          q_s = q_r;
        end
      end
      RUN: begin
        q_s   = step_q_s;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_mode_r <= USR_HOLD;
      cnt_r     <= CNT_ZERO;
      q_r       <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_mode_r <= op_mode_s;
      cnt_r     <= cnt_s;
      q_r       <= q_s;
      done_r    <= done_s;
    end
  end

  assign parallel_dout = q_r;
  assign s_left_dout   = q_r[WIDTH-1];
  assign s_right_dout  = q_r[0];
  assign busy          = (state_r == RUN);
  assign done          = done_r;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n (WIDTH=8): directed scenarios plus
// randomized single steps and start operations against an arithmetic model.
module tb_univ_shift_reg_n;

  localparam int W = 8;
  localparam int CW = $clog2(W) + 1;
  localparam int TOP = 2 ** (W - 1);
  localparam int MOD = 2 ** W;

  logic          clk = 1'b0;
  logic          rst, en, start, s_left_din, s_right_din;
  logic [2:0]    mode;
  logic [CW-1:0] shamt;
  logic [W-1:0]  parallel_din, parallel_dout;
  logic          s_left_dout, s_right_dout, busy, done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq;

  univ_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .shamt(shamt),
    .s_left_din(s_left_din), .s_right_din(s_right_din),
    .parallel_din(parallel_din), .parallel_dout(parallel_dout),
    .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: one step expressed as integer arithmetic on the register value
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] q, input logic [2:0] m,
                                            input logic sl, input logic sr,
                                            input logic [W-1:0] pd);
    int v, r;
    v = int'(q);
    case (m)
      3'd1:    r = v / 2 + (sr ? TOP : 0);
      3'd2:    r = (v * 2 + int'(sl)) % MOD;
      3'd3:    r = int'(pd);
      3'd4:    r = v / 2 + (v % 2) * TOP;
      3'd5:    r = (v * 2) % MOD + v / TOP;
      3'd6:    r = v / 2 + ((v >= TOP) ? TOP : 0);
      default: r = v;
    endcase
    return r[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] val);
    mode = 3'd3; en = 1'b1; start = 1'b0; parallel_din = val;
    tick();
    en = 1'b0;
    mq = val;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; mode = 3'd0; shamt = '0;
    s_left_din = 1'b0; s_right_din = 1'b0; parallel_din = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (parallel_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got dout=%h busy=%b done=%b expected 00/0/0", parallel_dout, busy, done);
    end
    load(8'hA5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = '0;
    checks++;
    if (parallel_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_load: got dout=%h busy=%b done=%b expected 00/0/0", parallel_dout, busy, done);
    end
  endtask

  task automatic test_directed_steps();
    logic [2:0]   modes [3] = '{3'd4, 3'd5, 3'd6};
    logic [W-1:0] exp_v [3] = '{8'hC0, 8'h03, 8'hC0};
    for (int i = 0; i < 3; i++) begin
      load(8'h81);
      mode = modes[i]; en = 1'b1;
      tick();
      en = 1'b0;
      checks++;
      if (parallel_dout !== exp_v[i]) begin
        errors++;
        $display("FAIL step_from_81 mode=%0d: got %h expected %h", modes[i], parallel_dout, exp_v[i]);
      end
      mq = parallel_dout;
    end
  endtask

  task automatic test_random_steps();
    logic [W-1:0] exp_q;
    for (int i = 0; i < 60; i++) begin
      mode = 3'($urandom_range(0, 7));
      en = 1'($urandom);
      s_left_din = 1'($urandom);
      s_right_din = 1'($urandom);
      parallel_din = W'($urandom);
      exp_q = en ? ref_step(mq, mode, s_left_din, s_right_din, parallel_din) : mq;
      tick();
      mq = exp_q;
      checks++;
      if (parallel_dout !== exp_q || s_left_dout !== exp_q[W-1] || s_right_dout !== exp_q[0]
          || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL random_step %0d: got dout=%h sl=%b sr=%b busy=%b done=%b expected dout=%h",
                 i, parallel_dout, s_left_dout, s_right_dout, busy, done, exp_q);
      end
    end
    en = 1'b0;
  endtask

  // Start an operation of k steps; inputs other than the serial/parallel data are scrambled while busy
  task automatic run_start(input logic [2:0] m, input int k);
    int rem, pulses;
    logic exp_done;
    logic [2:0] op;
    op = m;
    mode = m; shamt = CW'(k); start = 1'b1; en = 1'($urandom);
    tick();
    start = 1'b0;
    checks++;
    if (busy !== (k != 0) || done !== (k == 0) || parallel_dout !== mq) begin
      errors++;
      $display("FAIL start_accept k=%0d: got busy=%b done=%b dout=%h expected busy=%b done=%b dout=%h",
               k, busy, done, parallel_dout, k != 0, k == 0, mq);
    end
    pulses = done ? 1 : 0;
    rem = k;
    for (int i = 0; i < k + 2; i++) begin
      s_left_din = 1'($urandom);
      s_right_din = 1'($urandom);
      parallel_din = W'($urandom);
      exp_done = 1'b0;
      if (rem > 0) begin
        mode = 3'($urandom_range(0, 7));
        shamt = CW'($urandom);
        en = 1'($urandom);
        mq = ref_step(mq, op, s_left_din, s_right_din, parallel_din);
        rem--;
        exp_done = (rem == 0);
      end else begin
        en = 1'b0;
      end
      tick();
      if (done === 1'b1) pulses++;
      checks++;
      if (busy !== (rem > 0) || done !== exp_done || parallel_dout !== mq) begin
        errors++;
        $display("FAIL start_run mode=%0d k=%0d cyc=%0d: got busy=%b done=%b dout=%h expected busy=%b done=%b dout=%h",
                 op, k, i, busy, done, parallel_dout, rem > 0, exp_done, mq);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL done_pulse_count k=%0d: got %0d expected 1", k, pulses);
    end
  endtask

  task automatic test_start_directed();
    load(8'hB4);
    run_start(3'd5, 3);
    checks++;
    if (parallel_dout !== 8'hA5) begin
      errors++;
      $display("FAIL rol3_B4: got %h expected a5", parallel_dout);
    end
    load(8'h80);
    run_start(3'd6, 10);
    checks++;
    if (parallel_dout !== 8'hFF) begin
      errors++;
      $display("FAIL asr10_80: got %h expected ff", parallel_dout);
    end
    load(8'h5A);
    run_start(3'd1, 0);
    checks++;
    if (parallel_dout !== 8'h5A) begin
      errors++;
      $display("FAIL shamt0_5A: got %h expected 5a", parallel_dout);
    end
  endtask

  task automatic test_random_starts();
    for (int i = 0; i < 12; i++) begin
      load(W'($urandom));
      run_start(3'($urandom_range(0, 7)), $urandom_range(0, 2 ** CW - 1));
    end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    mode = 3'd5; shamt = CW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || parallel_dout !== 8'h04) begin
      errors++;
      $display("FAIL b2b_first: got done=%b busy=%b dout=%h expected 1/0/04", done, busy, parallel_dout);
    end
    mode = 3'd4; shamt = CW'(1); start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || parallel_dout !== 8'h04) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b dout=%h expected 0/1/04", done, busy, parallel_dout);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || parallel_dout !== 8'h02) begin
      errors++;
      $display("FAIL b2b_second: got done=%b busy=%b dout=%h expected 1/0/02", done, busy, parallel_dout);
    end
    mq = 8'h02;
    tick();
  endtask

  task automatic test_reset_in_run();
    int pulses;
    load(8'h3C);
    mode = 3'd1; shamt = CW'(4); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = '0;
    checks++;
    if (parallel_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_run: got dout=%h busy=%b done=%b expected 00/0/0", parallel_dout, busy, done);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || parallel_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_run_after: got %0d busy/done cycles dout=%h expected 0 cycles dout=00", pulses, parallel_dout);
    end
  endtask

  initial begin
    mq = '0;
    test_reset();
    test_directed_steps();
    test_random_steps();
    test_start_directed();
    test_back_to_back();
    test_reset_in_run();
    test_random_starts();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
